// File: rtl/wb_scoreboard_pkg.sv
// Shared types and widths for the writeback scoreboard slice.
package wb_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned LD_DEPTH_DEF = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t           addr;
        logic [XLEN_DEF-1:0] data;
    } wb_req_t;

    // A source/destination hit only counts for architectural registers other than x0.
    function automatic logic reg_hit(input reg_addr_t a, input reg_addr_t b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/wb_scoreboard_if.sv
// EX issue, load return, decode query and writeback signals of the scoreboard.
interface wb_scoreboard_if
    import wb_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned LD_DEPTH = LD_DEPTH_DEF
) ();
    localparam int unsigned CNT_W = $clog2(LD_DEPTH) + 1;

    logic             ex_valid;
    logic             ex_ready;
    logic             ex_we;
    logic             ex_is_load;
    reg_addr_t        ex_rd;
    logic [XLEN-1:0]  ex_data;
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;
    reg_addr_t        id_rs1;
    reg_addr_t        id_rs2;
    logic             id_stall;
    logic             wb_we;
    reg_addr_t        wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic [CNT_W-1:0] ld_pending;
    logic             err_unexp;

    modport master (
        output ex_valid, ex_we, ex_is_load, ex_rd, ex_data,
        output mem_rvalid, mem_rdata, id_rs1, id_rs2,
        input  ex_ready, id_stall, wb_we, wb_addr, wb_data, ld_pending, err_unexp
    );

    modport slave (
        input  ex_valid, ex_we, ex_is_load, ex_rd, ex_data,
        input  mem_rvalid, mem_rdata, id_rs1, id_rs2,
        output ex_ready, id_stall, wb_we, wb_addr, wb_data, ld_pending, err_unexp
    );

endinterface

// File: rtl/wb_scoreboard_ld_rd_fifo.sv
// In-order queue of outstanding load destinations with per-entry valid bits
// and a three-way lookup (rs1, rs2, ex_rd) against every live entry.
module wb_scoreboard_ld_rd_fifo
    import wb_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = LD_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  reg_addr_t                  push_rd_i,
    input  logic                       pop_i,
    output reg_addr_t                  head_rd_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    input  reg_addr_t                  rs1_i,
    input  reg_addr_t                  rs2_i,
    input  reg_addr_t                  ex_rd_i,
    output logic                       match_rs1_o,
    output logic                       match_rs2_o,
    output logic                       match_ex_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    reg_addr_t        rd_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign head_rd_o = rd_q[rd_ptr_q];

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) rd_q[i] <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                rd_q[wr_ptr_q]  <= push_rd_i;
                vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_comb begin
        match_rs1_o = 1'b0;
        match_rs2_o = 1'b0;
        match_ex_o  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match_rs1_o = match_rs1_o | (vld_q[i] && reg_hit(rs1_i, rd_q[i]));
            match_rs2_o = match_rs2_o | (vld_q[i] && reg_hit(rs2_i, rd_q[i]));
            match_ex_o  = match_ex_o  | (vld_q[i] && reg_hit(ex_rd_i, rd_q[i]));
        end
    end

endmodule

// File: rtl/wb_scoreboard.sv
// Writeback merge of ALU results and in-order load returns, with load-use stall
// and WAW hold. Optional WB_STALL_CNT_EN adds a saturating stall counter output.
module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int unsigned LD_DEPTH = LD_DEPTH_DEF,
    parameter int unsigned XLEN     = XLEN_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_scoreboard_if.slave bus
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]    stall_cnt_o
`endif
);
    localparam int unsigned CNT_W = $clog2(LD_DEPTH) + 1;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    reg_addr_t        fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             match_rs1, match_rs2, match_ex;

    logic             ex_writes, ex_ready_c, ex_fire, alu_acc, id_stall_c;

    logic             skid_v_q, skid_v_d;
    reg_addr_t        skid_addr_q, skid_addr_d;
    logic [XLEN-1:0]  skid_data_q, skid_data_d;
    logic             wb_we_q, wb_we_d;
    reg_addr_t        wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;
    logic             err_q, err_d;

    wb_scoreboard_ld_rd_fifo #(.DEPTH(LD_DEPTH)) u_ld_rd_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_rd_i   (bus.ex_rd),
        .pop_i       (fifo_pop),
        .head_rd_o   (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .rs1_i       (bus.id_rs1),
        .rs2_i       (bus.id_rs2),
        .ex_rd_i     (bus.ex_rd),
        .match_rs1_o (match_rs1),
        .match_rs2_o (match_rs2),
        .match_ex_o  (match_ex)
    );

    // Issue acceptance, queue control and decode hazard detection.
    always_comb begin
        ex_writes  = bus.ex_we && (bus.ex_rd != '0);
        ex_ready_c = !(skid_v_q
                       || (bus.ex_is_load && fifo_full && !bus.mem_rvalid)
                       || (ex_writes && match_ex));
        ex_fire    = bus.ex_valid && ex_ready_c;
        fifo_push  = ex_fire && bus.ex_is_load && ex_writes;
        alu_acc    = ex_fire && !bus.ex_is_load && ex_writes;
        fifo_pop   = bus.mem_rvalid && !fifo_empty;
        // The entry popped this cycle still stalls; forwarding covers the next cycle.
        id_stall_c = (bus.id_rs1 != '0 && (match_rs1 || (skid_v_q && skid_addr_q == bus.id_rs1)))
                  || (bus.id_rs2 != '0 && (match_rs2 || (skid_v_q && skid_addr_q == bus.id_rs2)));
    end

    // Write port arbitration: load return, then skid, then the new ALU result.
    always_comb begin
        wb_we_d     = 1'b0;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        skid_v_d    = skid_v_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        err_d       = err_q | (bus.mem_rvalid && fifo_empty);
        if (fifo_pop) begin
            wb_we_d   = 1'b1;
            wb_addr_d = fifo_head;
            wb_data_d = bus.mem_rdata;
            if (alu_acc) begin
                skid_v_d    = 1'b1;
                skid_addr_d = bus.ex_rd;
                skid_data_d = bus.ex_data;
            end
        end else if (skid_v_q) begin
            wb_we_d   = 1'b1;
            wb_addr_d = skid_addr_q;
            wb_data_d = skid_data_q;
            skid_v_d  = 1'b0;
        end else if (alu_acc) begin
            wb_we_d   = 1'b1;
            wb_addr_d = bus.ex_rd;
            wb_data_d = bus.ex_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_v_q    <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
            wb_we_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            skid_v_q    <= skid_v_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
            wb_we_q     <= wb_we_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
        end
    end

    assign bus.ex_ready   = ex_ready_c;
    assign bus.id_stall   = id_stall_c;
    assign bus.wb_we      = wb_we_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.ld_pending = fifo_count;
    assign bus.err_unexp  = err_q;

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where either decode or issue is held back; saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((id_stall_c || (bus.ex_valid && !ex_ready_c)) && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed, table-driven bench for wb_scoreboard plus reset / stray-return sequences.
module tb_wb_scoreboard;
    import wb_scoreboard_pkg::*;

    localparam int unsigned LD_DEPTH = 4;
    localparam int unsigned XLEN     = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_scoreboard_if #(.XLEN(XLEN), .LD_DEPTH(LD_DEPTH)) bus ();

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    wb_scoreboard #(.LD_DEPTH(LD_DEPTH), .XLEN(XLEN)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct {
        logic        v, we, ld;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        rv;
        logic [31:0] rdata;
        logic [4:0]  rs1, rs2;
        logic        e_rdy, e_stall, e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [3:0]  e_pend;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input int v, input int we, input int ld, input int rd,
                                input int d, input int rv, input int rdata,
                                input int rs1, input int rs2, input int e_rdy,
                                input int e_stall, input int e_we, input int e_addr,
                                input int e_data, input int e_pend);
        vec_t m;
        m.v = 1'(v);   m.we = 1'(we);   m.ld = 1'(ld);   m.rd = 5'(rd);
        m.d = 32'(d);  m.rv = 1'(rv);   m.rdata = 32'(rdata);
        m.rs1 = 5'(rs1); m.rs2 = 5'(rs2);
        m.e_rdy = 1'(e_rdy); m.e_stall = 1'(e_stall); m.e_we = 1'(e_we);
        m.e_addr = 5'(e_addr); m.e_data = 32'(e_data); m.e_pend = 4'(e_pend);
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.ex_valid   = t.v;
        bus.ex_we      = t.we;
        bus.ex_is_load = t.ld;
        bus.ex_rd      = t.rd;
        bus.ex_data    = t.d;
        bus.mem_rvalid = t.rv;
        bus.mem_rdata  = t.rdata;
        bus.id_rs1     = t.rs1;
        bus.id_rs2     = t.rs2;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        //                 v we ld rd data    rv rdata  rs1 rs2 rdy stl we addr data   pend
        tbl.push_back(mk(1, 1, 0,  5, 'h7,    0, 0,     0,  0,  1,  0,  1,  5,  'h7,   0)); // ALU x5=7
        tbl.push_back(mk(1, 1, 1,  3, 0,      0, 0,     0,  0,  1,  0,  0,  0,  0,     1)); // load x3
        tbl.push_back(mk(0, 0, 0,  0, 0,      0, 0,     3,  0,  1,  1,  0,  0,  0,     1)); // use x3
        tbl.push_back(mk(0, 0, 0,  0, 0,      0, 0,     3,  0,  1,  1,  0,  0,  0,     1));
        tbl.push_back(mk(0, 0, 0,  0, 0,      1, 'hAB,  3,  0,  1,  1,  1,  3,  'hAB,  0)); // return
        tbl.push_back(mk(0, 0, 0,  0, 0,      0, 0,     3,  0,  1,  0,  0,  0,  0,     0));
        tbl.push_back(mk(1, 1, 1,  6, 0,      0, 0,     0,  0,  1,  0,  0,  0,  0,     1)); // load x6
        tbl.push_back(mk(1, 1, 0,  7, 'h9,    1, 'h11,  0,  7,  1,  0,  1,  6,  'h11,  0)); // collide
        tbl.push_back(mk(1, 1, 0,  8, 'h22,   0, 0,     7,  0,  0,  1,  1,  7,  'h9,   0)); // skid out
        tbl.push_back(mk(1, 1, 0,  8, 'h22,   0, 0,     7,  0,  1,  0,  1,  8,  'h22,  0));
        tbl.push_back(mk(1, 1, 1,  4, 0,      0, 0,     0,  0,  1,  0,  0,  0,  0,     1)); // load x4
        tbl.push_back(mk(1, 1, 0,  4, 'h44,   0, 0,     0,  0,  0,  0,  0,  0,  0,     1)); // WAW hold
        tbl.push_back(mk(1, 1, 0,  4, 'h44,   1, 'h55,  0,  0,  0,  0,  1,  4,  'h55,  0));
        tbl.push_back(mk(1, 1, 0,  4, 'h44,   0, 0,     0,  0,  1,  0,  1,  4,  'h44,  0));
        tbl.push_back(mk(1, 1, 1,  0, 0,      0, 0,     0,  0,  1,  0,  0,  0,  0,     0)); // load x0
        tbl.push_back(mk(1, 1, 0,  0, 'h99,   0, 0,     0,  0,  1,  0,  0,  0,  0,     0)); // ALU x0
        tbl.push_back(mk(1, 0, 0,  9, 'h1,    0, 0,     0,  0,  1,  0,  0,  0,  0,     0)); // no we
        tbl.push_back(mk(1, 1, 1, 10, 0,      0, 0,     0,  0,  1,  0,  0,  0,  0,     1)); // fill
        tbl.push_back(mk(1, 1, 1, 11, 0,      0, 0,     0,  0,  1,  0,  0,  0,  0,     2));
        tbl.push_back(mk(1, 1, 1, 12, 0,      0, 0,     0,  0,  1,  0,  0,  0,  0,     3));
        tbl.push_back(mk(1, 1, 1, 13, 0,      0, 0,     0,  0,  1,  0,  0,  0,  0,     4));
        tbl.push_back(mk(1, 1, 1, 14, 0,      0, 0,     0,  0,  0,  0,  0,  0,  0,     4)); // full
        tbl.push_back(mk(1, 1, 1, 14, 0,      1, 'hA0,  0,  0,  1,  0,  1, 10,  'hA0,  4)); // push+pop
        tbl.push_back(mk(1, 1, 0, 15, 'h15,   0, 0,     0, 13,  1,  1,  1, 15,  'h15,  4));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst wb_we",      32'(bus.wb_we),      32'd0);
        check("rst wb_addr",    32'(bus.wb_addr),    32'd0);
        check("rst wb_data",    32'(bus.wb_data),    32'd0);
        check("rst ld_pending", 32'(bus.ld_pending), 32'd0);
        check("rst err_unexp",  32'(bus.err_unexp),  32'd0);
        check("rst ex_ready",   32'(bus.ex_ready),   32'd1);
        check("rst id_stall",   32'(bus.id_stall),   32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            check($sformatf("v%0d ex_ready", i), 32'(bus.ex_ready), 32'(tbl[i].e_rdy));
            check($sformatf("v%0d id_stall", i), 32'(bus.id_stall), 32'(tbl[i].e_stall));
            tick();
            check($sformatf("v%0d wb_we", i), 32'(bus.wb_we), 32'(tbl[i].e_we));
            if (tbl[i].e_we) begin
                check($sformatf("v%0d wb_addr", i), 32'(bus.wb_addr), 32'(tbl[i].e_addr));
                check($sformatf("v%0d wb_data", i), 32'(bus.wb_data), tbl[i].e_data);
            end
            check($sformatf("v%0d ld_pending", i), 32'(bus.ld_pending), 32'(tbl[i].e_pend));
        end
        idle();
        check("no stray err", 32'(bus.err_unexp), 32'd0);

        // Clean start, then two loads in flight when reset hits mid-cycle
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("clr ld_pending", 32'(bus.ld_pending), 32'd0);
        drive(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        drive(mk(1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        idle();
        check("two loads pending", 32'(bus.ld_pending), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst ld_pending", 32'(bus.ld_pending), 32'd0);
        check("async rst wb_we",      32'(bus.wb_we),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst err", 32'(bus.err_unexp), 32'd0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hEE;
        tick();
        idle();
        check("stray err_unexp",  32'(bus.err_unexp),  32'd1);
        check("stray wb_we",      32'(bus.wb_we),      32'd0);
        check("stray ld_pending", 32'(bus.ld_pending), 32'd0);
        tick();
        check("err sticky", 32'(bus.err_unexp), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
